pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage core. It merges stall requests from ID (load-use), EX (multi-cycle operations) and MEM (bus wait) with an exception flush request, and drives a single per-stage stall vector. It owns the cycle counter that holds EX for multi-cycle operations, and a saturating stall-cycle performance counter. It sits beside the pipeline registers (pc/if_id/id_ex/ex_mem/mem_wb), which consume `stall_o` and `flush_o`.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types.
//   stall_bus_t  : per-stage stall vector {wb,mem,ex,id,if,pc}, bit0 = pc
//   STALL_*      : stall encodings, each freezing its stage and everything upstream
//   ctrl_state_e : sequencing FSM states
package pipe_ctrl_pkg;

  typedef logic [5:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_IDLE  = 1'b0,
    CTRL_MULTI = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, with synchronous
// clear taking priority over increment. Reusable for any perf event.
//   clk, rst : clock, async active-low reset
//   clr_i    : synchronous clear
//   inc_i    : count this cycle
//   cnt_o    : registered count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencing controller.
// Merges flush / MEM / EX / ID stall sources into one stall vector, runs the
// multi-cycle EX hold counter, and counts stalled cycles.
//   clk, rst          : clock, async active-low reset
//   stallreq_id_i     : ID load-use hazard
//   stallreq_mem_i    : MEM bus not ready (freezes the whole controller)
//   ex_multi_start_i  : multi-cycle op in EX, only looked at in IDLE
//   ex_multi_len_i    : total EX occupancy N
//   flush_req_i       : exception/eret flush
//   perf_clr_i        : clear stall counter
//   stall_o, flush_o, ex_done_o : same-cycle combinational outputs
//   ex_busy_o         : registered, op in progress
//   stall_cnt_o       : registered saturating count of stall cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_mem_i,
  input  logic              ex_multi_start_i,
  input  logic [CNT_W-1:0]  ex_multi_len_i,
  input  logic              flush_req_i,
  input  logic              perf_clr_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              ex_busy_o,
  output logic              ex_done_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_o   = STALL_NONE;
    flush_o   = 1'b0;
    ex_done_o = 1'b0;
    ex_stall  = 1'b0;
    // Outputs are forced quiet while reset is held, even with requests high.
    if (rst) begin
      if (flush_req_i) begin
        flush_o = 1'b1;
        state_d = CTRL_IDLE;
        cnt_d   = '0;
      end else if (stallreq_mem_i) begin
        // Freeze: state and count hold, done is withheld until MEM releases.
        stall_o = STALL_MEM;
      end else begin
        case (state_q)
          CTRL_IDLE: begin
            if (ex_multi_start_i) begin
              if (ex_multi_len_i >= CNT_W'(2)) begin
                // N-1 stall cycles remain including this one; cnt counts the rest.
                ex_stall = 1'b1;
                cnt_d    = ex_multi_len_i - CNT_W'(2);
                state_d  = CTRL_MULTI;
              end else begin
                ex_done_o = 1'b1;
              end
            end
          end
          CTRL_MULTI: begin
            if (cnt_q != '0) begin
              ex_stall = 1'b1;
              cnt_d    = cnt_q - CNT_W'(1);
            end else begin
              ex_done_o = 1'b1;
              state_d   = CTRL_IDLE;
            end
          end
          default: state_d = CTRL_IDLE;
        endcase
        if (ex_stall)           stall_o = STALL_EX;
        else if (stallreq_id_i) stall_o = STALL_ID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CTRL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_busy_o = (state_q == CTRL_MULTI);

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (perf_clr_i),
    .inc_i (stall_o != STALL_NONE),
    .cnt_o (stall_cnt_o)
  );

endmodule
